// File: rtl/sirv_gnrl_pipe_buf_pkg.sv
// sirv_gnrl_pipe_buf_pkg: shared defaults and sizing helpers for the pipeline buffer.
package sirv_gnrl_pipe_buf_pkg;

    localparam int PB_DW = 32;
    localparam int PB_DP = 2;

    // A single-entry buffer has no real pointer; keep one bit that is held at 0.
    function automatic int ptr_w(input int dp);
        return (dp > 1) ? $clog2(dp) : 1;
    endfunction

endpackage

// File: rtl/sirv_gnrl_pipe_buf_dffs.sv
// sirv_gnrl_pipe_buf_dffs: load-enable flops used for buffer entries and control state.
//  sirv_gnrl_dffl : clk, lden, dnxt[DW] -> qout[DW], no reset
//  sirv_gnrl_dfflr: clk, rst_n, lden, dnxt[DW] -> qout[DW], async clear to 0
module sirv_gnrl_dffl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk) begin
        if (lden) qout <= dnxt;
    end

endmodule

module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) qout <= '0;
        else if (lden) qout <= dnxt;
    end

endmodule

// File: rtl/sirv_gnrl_pipe_buf.sv
// sirv_gnrl_pipe_buf: DP-entry valid/ready FIFO buffer with optional ready cut and flush.
//  clk, rst_n (async active-low), flush: discard contents at next edge
//  i_vld/i_rdy/i_dat: producer side; o_vld/o_rdy/o_dat: consumer side (oldest word)
//  cnt: occupancy 0..DP
module sirv_gnrl_pipe_buf import sirv_gnrl_pipe_buf_pkg::*; #(
    parameter int DW        = PB_DW,
    parameter int DP        = PB_DP,
    parameter int CUT_READY = 1,
    parameter int DATA_RST  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     i_vld,
    output logic                     i_rdy,
    input  logic [DW-1:0]            i_dat,
    output logic                     o_vld,
    input  logic                     o_rdy,
    output logic [DW-1:0]            o_dat,
    output logic [$clog2(DP+1)-1:0]  cnt
);

    localparam int PW = ptr_w(DP);
    localparam int CW = $clog2(DP + 1);

    logic [PW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          full, push, pop;
    logic [DW-1:0] mem [DP];

    assign full  = cnt == CW'(DP);
    // Without the cut, a full buffer may still accept when the head leaves this cycle.
    assign i_rdy = (~full | ((CUT_READY == 0) & o_rdy)) & ~flush;
    assign o_vld = (cnt != '0) & ~flush;
    assign push  = i_vld & i_rdy;
    assign pop   = o_vld & o_rdy;

    // Wrap by compare so non-power-of-two depths work; with DP=1 the pointers stay 0.
    always_comb begin
        wptr_nxt = flush ? '0 : (wptr == PW'(DP - 1)) ? '0 : wptr + 1'b1;
        rptr_nxt = flush ? '0 : (rptr == PW'(DP - 1)) ? '0 : rptr + 1'b1;
        cnt_nxt  = flush ? '0 : push ? cnt + 1'b1 : cnt - 1'b1;
    end

    sirv_gnrl_dfflr #(.DW(PW)) u_wptr (
        .clk(clk), .rst_n(rst_n), .lden(push | flush), .dnxt(wptr_nxt), .qout(wptr)
    );
    sirv_gnrl_dfflr #(.DW(PW)) u_rptr (
        .clk(clk), .rst_n(rst_n), .lden(pop | flush), .dnxt(rptr_nxt), .qout(rptr)
    );
    // cnt only moves when exactly one of push/pop happens.
    sirv_gnrl_dfflr #(.DW(CW)) u_cnt (
        .clk(clk), .rst_n(rst_n), .lden(flush | (push ^ pop)), .dnxt(cnt_nxt), .qout(cnt)
    );

    for (genvar i = 0; i < DP; i++) begin : g_ent
        logic lden;
        assign lden = push & (wptr == PW'(i));
        if (DATA_RST != 0) begin : g_rst
            sirv_gnrl_dfflr #(.DW(DW)) u_dat (
                .clk(clk), .rst_n(rst_n), .lden(lden), .dnxt(i_dat), .qout(mem[i])
            );
        end else begin : g_nrst
            sirv_gnrl_dffl #(.DW(DW)) u_dat (
                .clk(clk), .lden(lden), .dnxt(i_dat), .qout(mem[i])
            );
        end
    end

    if (DP == 1) begin : g_one
        assign o_dat = mem[0];
    end else begin : g_many
        assign o_dat = mem[rptr];
    end

`ifdef SIMULATION
`ifdef ENABLE_SV_ASSERTION
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown({i_vld, o_rdy, flush}));
            assert (cnt <= CW'(DP));
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        ($past(i_vld & ~i_rdy) & i_vld) |-> $stable(i_dat));
`endif
`endif

endmodule

// File: tb/tb_sirv_gnrl_pipe_buf.sv
// tb_sirv_gnrl_pipe_buf: scoreboard bench driving six buffer configurations from shared inputs.
module tb_sirv_gnrl_pipe_buf;

    logic       clk = 1'b0;
    logic       rst_n, flush, i_vld, o_rdy;
    logic [7:0] i_dat;

    logic       rdy [6];
    logic       vld [6];
    logic [7:0] dat [6];
    logic [1:0] cn0, cn1;
    logic [0:0] cn2, cn3;
    logic [2:0] cn4, cn5;

    int dp  [6] = '{2, 3, 1, 1, 4, 5};
    int cut [6] = '{1, 1, 0, 1, 1, 0};

    logic [7:0] q[$];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sirv_gnrl_pipe_buf #(.DW(8), .DP(2), .CUT_READY(1), .DATA_RST(0)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(rdy[0]), .i_dat(i_dat),
        .o_vld(vld[0]), .o_rdy(o_rdy), .o_dat(dat[0]), .cnt(cn0));
    sirv_gnrl_pipe_buf #(.DW(8), .DP(3), .CUT_READY(1), .DATA_RST(0)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(rdy[1]), .i_dat(i_dat),
        .o_vld(vld[1]), .o_rdy(o_rdy), .o_dat(dat[1]), .cnt(cn1));
    sirv_gnrl_pipe_buf #(.DW(8), .DP(1), .CUT_READY(0), .DATA_RST(0)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(rdy[2]), .i_dat(i_dat),
        .o_vld(vld[2]), .o_rdy(o_rdy), .o_dat(dat[2]), .cnt(cn2));
    sirv_gnrl_pipe_buf #(.DW(8), .DP(1), .CUT_READY(1), .DATA_RST(0)) u3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(rdy[3]), .i_dat(i_dat),
        .o_vld(vld[3]), .o_rdy(o_rdy), .o_dat(dat[3]), .cnt(cn3));
    sirv_gnrl_pipe_buf #(.DW(8), .DP(4), .CUT_READY(1), .DATA_RST(0)) u4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(rdy[4]), .i_dat(i_dat),
        .o_vld(vld[4]), .o_rdy(o_rdy), .o_dat(dat[4]), .cnt(cn4));
    sirv_gnrl_pipe_buf #(.DW(8), .DP(5), .CUT_READY(0), .DATA_RST(1)) u5 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(rdy[5]), .i_dat(i_dat),
        .o_vld(vld[5]), .o_rdy(o_rdy), .o_dat(dat[5]), .cnt(cn5));

    function automatic logic [31:0] cnt_of(input int k);
        case (k)
            0: return 32'(cn0);
            1: return 32'(cn1);
            2: return 32'(cn2);
            3: return 32'(cn3);
            4: return 32'(cn4);
            default: return 32'(cn5);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called just after an active edge with the next inputs already driven.
    task automatic sb_cycle(input int k);
        logic er, ev;
        #1;
        ev = (q.size() != 0) && !flush;
        er = ((q.size() != dp[k]) || (cut[k] == 0 && o_rdy)) && !flush;
        chk($sformatf("u%0d i_rdy", k), 32'(rdy[k]), 32'(er));
        chk($sformatf("u%0d o_vld", k), 32'(vld[k]), 32'(ev));
        chk($sformatf("u%0d cnt", k), cnt_of(k), 32'(q.size()));
        if (ev && o_rdy) begin
            chk($sformatf("u%0d o_dat", k), 32'(dat[k]), 32'(q[0]));
            void'(q.pop_front());
        end
        if (er && i_vld) q.push_back(i_dat);
        if (flush) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        flush = 1'b0;
        i_vld = 1'b0;
        o_rdy = 1'b0;
        i_dat = 8'h00;
        #2;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rst u%0d i_rdy", k), 32'(rdy[k]), 32'd1);
            chk($sformatf("rst u%0d o_vld", k), 32'(vld[k]), 32'd0);
            chk($sformatf("rst u%0d cnt", k), cnt_of(k), 32'd0);
        end
        chk("rst u5 o_dat", 32'(dat[5]), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
    endtask

    initial begin
        do_reset();

        // DP=2 cut: fill, confirm stall, then drain in order
        i_vld = 1'b1; i_dat = 8'hA5; sb_cycle(0);
        i_dat = 8'h3C; sb_cycle(0);
        i_vld = 1'b0; sb_cycle(0);
        chk("t1 cnt full", cnt_of(0), 32'd2);
        o_rdy = 1'b1;
        for (int n = 0; n < 3; n++) sb_cycle(0);
        chk("t1 cnt drained", cnt_of(0), 32'd0);

        // DP=3 streaming 1..9
        do_reset();
        i_vld = 1'b1; o_rdy = 1'b1;
        for (int v = 1; v <= 9; v++) begin
            i_dat = 8'(v);
            sb_cycle(1);
        end
        i_vld = 1'b0;
        sb_cycle(1);
        sb_cycle(1);

        // DP=1 without cut: pop and push together while full
        do_reset();
        i_vld = 1'b1; i_dat = 8'h11; sb_cycle(2);
        i_dat = 8'h55; o_rdy = 1'b1; sb_cycle(2);
        chk("t3a cnt", cnt_of(2), 32'd1);
        chk("t3a o_dat", 32'(dat[2]), 32'h55);
        i_vld = 1'b0; sb_cycle(2);
        sb_cycle(2);

        // DP=1 with cut: push held while full
        do_reset();
        i_vld = 1'b1; i_dat = 8'h11; sb_cycle(3);
        i_dat = 8'h55; o_rdy = 1'b1; sb_cycle(3);
        sb_cycle(3);
        i_vld = 1'b0; sb_cycle(3);
        sb_cycle(3);

        // DP=4 flush when full
        do_reset();
        i_vld = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            i_dat = 8'(v * 8'h11);
            sb_cycle(4);
        end
        flush = 1'b1; o_rdy = 1'b1; i_dat = 8'h77; sb_cycle(4);
        flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b0;
        #1;
        chk("t4 cnt", cnt_of(4), 32'd0);
        chk("t4 o_vld", 32'(vld[4]), 32'd0);
        chk("t4 i_rdy", 32'(rdy[4]), 32'd1);
        i_vld = 1'b1; i_dat = 8'h66; sb_cycle(4);
        i_vld = 1'b0; o_rdy = 1'b1; sb_cycle(4);
        sb_cycle(4);

        // DP=2 reset pulse between edges
        do_reset();
        i_vld = 1'b1; i_dat = 8'h21; sb_cycle(0);
        i_dat = 8'h42; sb_cycle(0);
        i_vld = 1'b0;
        #2;
        chk("t5 o_vld before", 32'(vld[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5 o_vld async", 32'(vld[0]), 32'd0);
        chk("t5 cnt async", cnt_of(0), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t5 i_rdy release", 32'(rdy[0]), 32'd1);
        q.delete();
        @(posedge clk);
        #1;
        i_vld = 1'b1; i_dat = 8'h99; sb_cycle(0);
        i_vld = 1'b0; o_rdy = 1'b1; sb_cycle(0);
        sb_cycle(0);

        // DP=5 random traffic
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            i_vld = 1'($urandom_range(0, 1));
            o_rdy = 1'($urandom_range(0, 1));
            i_dat = 8'($urandom);
            flush = ($urandom_range(0, 63) == 0);
            sb_cycle(5);
        end
        flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b1;
        for (int n = 0; n < 6; n++) sb_cycle(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
